// File: rtl/uart_rx_frame_if.sv
// ============================================================================
//  Module      : uart_rx_frame_if
//  Description : Received-word handshake bundle between the UART receive
//                engine (master) and its consumer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  overrun,
        output rx_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
//  Module      : uart_rx_frame
//  Description : Oversampling UART receiver, configurable width/parity/stop,
//                delivering words on a valid/ready port with error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       tick,
    input  wire logic       rxd,
    uart_rx_frame_if.master rx_if
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_IDX_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_TICK_W-1:0] c_HALF_M1   = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_FULL_M1   = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_IDX_W-1:0]  c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0]  c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);
    localparam logic                c_ODD       = (PARITY_ODD != 0);
    localparam logic                c_PAR_EN    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic                 r_sync1;
    logic                 r_rxd_s;
    state_t               r_state;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic                 r_perr;

    state_t               w_state_next;
    logic [c_TICK_W-1:0]  w_cnt_next;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_ferr_next;
    logic                 w_perr_next;
    logic                 w_done;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxd_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_cnt_next;
            r_bit_idx  <= w_idx_next;
            r_shift    <= w_shift_next;
            r_ferr     <= w_ferr_next;
            r_perr     <= w_perr_next;
        end
    end

    // Everything below only moves on tick cycles; otherwise it holds.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_tick_cnt;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_ferr_next  = r_ferr;
        w_perr_next  = r_perr;
        w_done       = 1'b0;
        if (tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxd_s) begin
                        w_cnt_next   = '0;
                        w_ferr_next  = 1'b0;
                        w_perr_next  = 1'b0;
                        w_state_next = S_START;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == c_HALF_M1) begin
                        w_cnt_next = '0;
                        if (r_rxd_s) begin
                            w_state_next = S_IDLE;
                        end else begin
                            w_idx_next   = '0;
                            w_state_next = S_DATA;
                        end
                    end else begin
                        w_cnt_next = r_tick_cnt + c_TICK_ONE;
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == c_FULL_M1) begin
                        w_cnt_next   = '0;
                        w_shift_next = {r_rxd_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == c_DATA_LAST) begin
                            w_idx_next   = '0;
                            w_state_next = c_PAR_EN ? S_PARITY : S_STOP;
                        end else begin
                            w_idx_next = r_bit_idx + c_IDX_ONE;
                        end
                    end else begin
                        w_cnt_next = r_tick_cnt + c_TICK_ONE;
                    end
                end
                S_PARITY: begin
                    if (r_tick_cnt == c_FULL_M1) begin
                        w_cnt_next   = '0;
                        w_perr_next  = (^r_shift) ^ r_rxd_s ^ c_ODD;
                        w_idx_next   = '0;
                        w_state_next = S_STOP;
                    end else begin
                        w_cnt_next = r_tick_cnt + c_TICK_ONE;
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == c_FULL_M1) begin
                        w_cnt_next = '0;
                        if (!r_rxd_s) begin
                            w_ferr_next = 1'b1;
                        end
                        if (r_bit_idx == c_STOP_LAST) begin
                            w_done       = 1'b1;
                            w_idx_next   = '0;
                            w_state_next = r_rxd_s ? S_IDLE : S_BREAK;
                        end else begin
                            w_idx_next = r_bit_idx + c_IDX_ONE;
                        end
                    end else begin
                        w_cnt_next = r_tick_cnt + c_TICK_ONE;
                    end
                end
                S_BREAK: begin
                    if (r_rxd_s) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // A completed frame is dropped only when the held word is not being taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_valid || rx_if.rx_ready) begin
                    r_data       <= r_shift;
                    r_frame_err  <= w_ferr_next;
                    r_parity_err <= r_perr & c_PAR_EN;
                    r_valid      <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = r_data;
    assign rx_if.rx_valid   = r_valid;
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.parity_err = r_parity_err;
    assign rx_if.overrun    = r_overrun;

endmodule

`default_nettype wire
